// File: rtl/sw_lap_ctrl_if.sv
// sw_lap_ctrl_if: button/time inputs and display/status outputs of the stopwatch control block.
interface sw_lap_ctrl_if #(parameter int AW = 3);
   logic          i_fStart;
   logic          i_fStop;
   logic          i_fLap;
   logic [11:0]   i_Time;
   logic          o_Run;
   logic          o_Clear;
   logic [11:0]   o_Disp;
   logic [AW-1:0] o_LapIdx;
   logic [AW:0]   o_LapCnt;
   logic          o_Full;
   logic [1:0]    o_State;
   modport master (
      output i_fStart, i_fStop, i_fLap, i_Time,
      input  o_Run, o_Clear, o_Disp, o_LapIdx, o_LapCnt, o_Full, o_State
   );
   modport slave (
      input  i_fStart, i_fStop, i_fLap, i_Time,
      output o_Run, o_Clear, o_Disp, o_LapIdx, o_LapCnt, o_Full, o_State
   );
endinterface

// File: rtl/sw_lap_ctrl.sv
// sw_lap_ctrl: debounced button FSM driving counter run/clear and a lap memory with review stepping.
module sw_lap_ctrl #(
   parameter int DB_CNT = 2_000_000,
   parameter int DEPTH  = 8,
   parameter int AW     = 3
) (
   input logic          i_Clk,
   input logic          i_Rst,
   sw_lap_ctrl_if.slave bus
);
   localparam int CW = $clog2(DB_CNT + 1);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, REVIEW} state_t;
   logic [2:0]    btn, sync1_q, sync2_q, stb_q, stb_d, prv_q, prs;
   logic [CW-1:0] dbc_q [3];
   logic [CW-1:0] dbc_d [3];
   logic          st, sp, lp, wr;
   state_t        state_q, state_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d, last, sel;
   logic [11:0]   mem_q [DEPTH];
   assign btn = {bus.i_fStart, bus.i_fStop, bus.i_fLap};
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         stb_q   <= '1;
         prv_q   <= '1;
         dbc_q   <= '{default: '0};
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         stb_q   <= stb_d;
         prv_q   <= stb_q;
         dbc_q   <= dbc_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end
   // The stable level flips on the cycle the counter would have reached DB_CNT.
   always_comb begin
      stb_d = stb_q;
      for (int i = 0; i < 3; i++) begin
         dbc_d[i] = '0;
         if (sync2_q[i] != stb_q[i]) begin
            if (dbc_q[i] == CW'(DB_CNT - 1)) stb_d[i] = ~stb_q[i];
            else dbc_d[i] = dbc_q[i] + CW'(1);
         end
      end
   end
   assign prs  = ~stb_q & prv_q;
   assign st   = prs[2];
   assign sp   = prs[1] & ~prs[2];
   assign lp   = prs[0] & ~|prs[2:1];
   assign last = cnt_q[AW-1:0] - AW'(1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr      = 1'b0;
      case (state_q)
         IDLE: if (st) state_d = RUN;
         RUN: begin
            if (st) state_d = PAUSE;
            else if (sp) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (lp && cnt_q < (AW+1)'(DEPTH)) begin
               wr    = 1'b1;
               cnt_d = cnt_q + (AW+1)'(1);
            end
         end
         PAUSE: begin
            if (st) state_d = RUN;
            else if (sp) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (lp && cnt_q != '0) begin
               state_d = REVIEW;
               idx_d   = '0;
            end
         end
         REVIEW: begin
            if (st) state_d = RUN;
            else if (sp) state_d = PAUSE;
            else if (lp) idx_d = (idx_q == last) ? '0 : idx_q + AW'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   // Lap storage is never reset; a zero lap count hides stale entries.
   always_ff @(posedge i_Clk)
      if (wr) mem_q[cnt_q[AW-1:0]] <= bus.i_Time;
   assign sel          = (state_q == REVIEW) ? idx_q : (cnt_q != '0 ? last : '0);
   assign bus.o_State  = state_q;
   assign bus.o_Run    = state_q == RUN;
   assign bus.o_Clear  = state_q == IDLE;
   assign bus.o_LapCnt = cnt_q;
   assign bus.o_Full   = cnt_q == (AW+1)'(DEPTH);
   assign bus.o_LapIdx = sel;
   assign bus.o_Disp   = (cnt_q == '0) ? 12'h000 : mem_q[sel];
endmodule

// File: tb/tb_sw_lap_ctrl.sv
// tb_sw_lap_ctrl: vector table, hand-written corner sequences and random presses against a lap-list model.
module tb_sw_lap_ctrl;
   localparam logic [2:0] S = 3'b100, P = 3'b010, L = 3'b001;
   logic i_Clk = 1'b0;
   logic i_Rst = 1'b0;
   always #5 i_Clk = ~i_Clk;
   sw_lap_ctrl_if #(.AW(3)) bus ();
   sw_lap_ctrl #(.DB_CNT(4), .DEPTH(8), .AW(3)) dut (.i_Clk(i_Clk), .i_Rst(i_Rst), .bus(bus));
   int n_cmp = 0;
   int n_err = 0;
   typedef struct {
      logic [2:0]  b;
      logic [11:0] t;
      int          st, cnt, disp, idx;
   } vec_t;
   vec_t v[$];
   int m_state, m_idx;
   logic [11:0] laps[$];
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic chk_all(input string tag, input int st, input int cnt, input int disp, input int idx);
      chk({tag, " state"}, int'(bus.o_State), st);
      chk({tag, " run"}, int'(bus.o_Run), int'(st == 1));
      chk({tag, " clear"}, int'(bus.o_Clear), int'(st == 0));
      chk({tag, " lapcnt"}, int'(bus.o_LapCnt), cnt);
      chk({tag, " disp"}, int'(bus.o_Disp), disp);
      chk({tag, " lapidx"}, int'(bus.o_LapIdx), idx);
      chk({tag, " full"}, int'(bus.o_Full), int'(cnt == 8));
   endtask
   task automatic cycles(input int n);
      repeat (n) @(negedge i_Clk);
   endtask
   task automatic press(input logic [2:0] m, input logic [11:0] t);
      bus.i_Time = t;
      {bus.i_fStart, bus.i_fStop, bus.i_fLap} = ~m;
      cycles(10);
      {bus.i_fStart, bus.i_fStop, bus.i_fLap} = 3'b111;
      cycles(10);
   endtask
   task automatic do_reset();
      i_Rst = 1'b0;
      cycles(2);
      i_Rst = 1'b1;
      cycles(2);
      m_state = 0;
      m_idx   = 0;
      laps.delete();
   endtask
   function automatic void model(input logic [2:0] m, input logic [11:0] t);
      if (m[2]) m_state = (m_state == 1) ? 2 : 1;
      else if (m[1]) begin
         if (m_state == 3) m_state = 2;
         else if (m_state != 0) begin
            m_state = 0;
            laps.delete();
         end
      end else if (m[0]) begin
         if (m_state == 1 && laps.size() < 8) laps.push_back(t);
         else if (m_state == 2 && laps.size() > 0) begin
            m_state = 3;
            m_idx   = 0;
         end else if (m_state == 3) m_idx = (m_idx + 1) % laps.size();
      end
   endfunction
   task automatic check_model(input string tag);
      int n, d, x;
      n = laps.size();
      d = (m_state == 3) ? int'(laps[m_idx]) : (n > 0 ? int'(laps[n-1]) : 0);
      x = (m_state == 3) ? m_idx : (n > 0 ? n - 1 : 0);
      chk_all(tag, m_state, n, d, x);
   endtask
   initial begin
      int prev, chg;
      logic [2:0] m;
      logic [11:0] t;
      bus.i_fStart = 1'b1;
      bus.i_fStop  = 1'b1;
      bus.i_fLap   = 1'b1;
      bus.i_Time   = '0;
      #1 chk_all("reset", 0, 0, 0, 0);
      do_reset();
      chk_all("after reset", 0, 0, 0, 0);
      bus.i_fStart = 1'b0;
      cycles(3);
      bus.i_fStart = 1'b1;
      cycles(20);
      chk_all("glitch", 0, 0, 0, 0);
      prev = int'(bus.o_State);
      chg  = 0;
      bus.i_fStart = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge i_Clk);
         if (k == 6) chk("latency edge6 state", int'(bus.o_State), 0);
         if (k == 7) chk_all("latency edge7", 1, 0, 0, 0);
         if (int'(bus.o_State) != prev) chg++;
         prev = int'(bus.o_State);
      end
      chk("held transitions", chg, 1);
      bus.i_fStart = 1'b1;
      cycles(10);
      chk_all("release", 1, 0, 0, 0);
      do_reset();
      v.push_back('{P, 12'h000, 0, 0, 12'h000, 0});
      v.push_back('{L, 12'h000, 0, 0, 12'h000, 0});
      v.push_back('{S, 12'h000, 1, 0, 12'h000, 0});
      v.push_back('{L, 12'h123, 1, 1, 12'h123, 0});
      v.push_back('{L, 12'h456, 1, 2, 12'h456, 1});
      for (int i = 3; i <= 8; i++) v.push_back('{L, 12'h600 + 12'(i), 1, i, 12'h600 + i, i - 1});
      v.push_back('{L, 12'h777, 1, 8, 12'h608, 7});
      v.push_back('{L, 12'h888, 1, 8, 12'h608, 7});
      v.push_back('{P | L, 12'h000, 0, 0, 12'h000, 0});
      v.push_back('{S, 12'h000, 1, 0, 12'h000, 0});
      v.push_back('{L, 12'h011, 1, 1, 12'h011, 0});
      v.push_back('{L, 12'h022, 1, 2, 12'h022, 1});
      v.push_back('{L, 12'h033, 1, 3, 12'h033, 2});
      v.push_back('{S, 12'h000, 2, 3, 12'h033, 2});
      v.push_back('{L, 12'h000, 3, 3, 12'h011, 0});
      v.push_back('{L, 12'h000, 3, 3, 12'h022, 1});
      v.push_back('{L, 12'h000, 3, 3, 12'h033, 2});
      v.push_back('{L, 12'h000, 3, 3, 12'h011, 0});
      v.push_back('{P, 12'h000, 2, 3, 12'h033, 2});
      v.push_back('{L, 12'h000, 3, 3, 12'h011, 0});
      v.push_back('{S, 12'h000, 1, 3, 12'h033, 2});
      v.push_back('{S | P, 12'h000, 2, 3, 12'h033, 2});
      v.push_back('{P, 12'h000, 0, 0, 12'h000, 0});
      v.push_back('{S, 12'h000, 1, 0, 12'h000, 0});
      v.push_back('{S, 12'h000, 2, 0, 12'h000, 0});
      v.push_back('{L, 12'h000, 2, 0, 12'h000, 0});
      v.push_back('{S | L, 12'h999, 1, 0, 12'h000, 0});
      v.push_back('{L, 12'h0ab, 1, 1, 12'h0ab, 0});
      foreach (v[i]) begin
         press(v[i].b, v[i].t);
         chk_all($sformatf("vec%0d", i), v[i].st, v[i].cnt, v[i].disp, v[i].idx);
      end
      do_reset();
      press(S, 12'h000);
      press(L, 12'h101);
      press(L, 12'h202);
      press(S, 12'h000);
      press(L, 12'h000);
      press(L, 12'h000);
      chk_all("review before reset", 3, 2, 12'h202, 1);
      #2 i_Rst = 1'b0;
      #1 chk_all("async reset", 0, 0, 0, 0);
      cycles(2);
      i_Rst = 1'b1;
      cycles(2);
      chk_all("after async reset", 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: m = L;
            4, 5:       m = S;
            6:          m = P;
            default:    m = 3'($urandom_range(1, 7));
         endcase
         t = 12'($urandom);
         press(m, t);
         model(m, t);
         check_model($sformatf("rand%0d", i));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
